// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes, FSM states, byte counts.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } lsu_state_t;

  function automatic logic [3:0] byte_count(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response bus between execute and the LSU, and the LSU-to-data-memory bus.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

interface lsu_mem_if;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_read_data;

  modport master (
    output mem_address, mem_write_data, mem_read, mem_write,
    input  mem_read_data
  );
  modport slave (
    input  mem_address, mem_write_data, mem_read, mem_write,
    output mem_read_data
  );
endinterface

// File: rtl/lsu_align_unit.sv
// Combinational datapath: extends the low bytes of the memory window for loads and
// merges store bytes into the window for read-modify-write.
module lsu_align_unit
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [63:0] i_rdata,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_load_data,
  output logic [63:0] o_store_data
);

  logic [63:0] w_mask;
  logic        w_sign;

  // NOTE: every output is assigned up front so no path through this block infers a latch.
  always_comb begin
    w_mask = ~(64'hFFFF_FFFF_FFFF_FFFF << {byte_count(i_size), 3'b000});
    case (i_size)
      SZ_B:    w_sign = i_rdata[7];
      SZ_H:    w_sign = i_rdata[15];
      SZ_W:    w_sign = i_rdata[31];
      default: w_sign = 1'b0;
    endcase
    o_load_data = i_rdata & w_mask;
    if (w_sign && !i_unsigned) o_load_data = o_load_data | ~w_mask;
    o_store_data = (i_rdata & ~w_mask) | (i_wdata & w_mask);
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the 64-bit byte-addressed data memory; one request at a time.
// Optional LSU_ALIGN_CHECK_EN: naturally misaligned H/W/D accesses also fault.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic      clk,
  input  logic      reset,
  lsu_req_if.slave  req_bus,
  lsu_mem_if.master mem_bus
);

  localparam logic [63:0] LAST_START = 64'(MEM_BYTES - 8);

  lsu_state_t  r_state;
  logic        r_pending;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [63:0] r_resp_rdata;
  logic        r_resp_fault;
  logic [63:0] r_mem_address;
  logic [63:0] r_mem_write_data;
  logic        r_mem_read;
  logic        r_mem_write;

  logic [63:0] w_load_data;
  logic [63:0] w_store_data;
  logic        w_misaligned;
  logic        w_fault;

`ifdef LSU_ALIGN_CHECK_EN
  always_comb begin
    case (r_size)
      SZ_H:    w_misaligned = r_addr[0];
      SZ_W:    w_misaligned = |r_addr[1:0];
      SZ_D:    w_misaligned = |r_addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end
`else
  assign w_misaligned = 1'b0;
`endif

  // The memory always touches a full 8-byte window, whatever the access size.
  assign w_fault = (r_addr > LAST_START) || w_misaligned;

  lsu_align_unit u_align (
    .i_size       (r_size),
    .i_unsigned   (r_unsigned),
    .i_rdata      (mem_bus.mem_read_data),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_data (w_store_data)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_pending        <= 1'b0;
      r_write          <= 1'b0;
      r_size           <= SZ_B;
      r_unsigned       <= 1'b0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_req_ready      <= 1'b1;
      r_resp_valid     <= 1'b0;
      r_resp_rdata     <= '0;
      r_resp_fault     <= 1'b0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // The accept cycle only registers the request; dispatch uses the registered copy.
          if (r_pending) begin
            r_pending <= 1'b0;
            if (w_fault) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
            end else if (!r_write) begin
              r_state       <= LOAD;
              r_mem_read    <= 1'b1;
              r_mem_address <= r_addr;
            end else if (r_size == SZ_D) begin
              r_state          <= WRITE;
              r_mem_write      <= 1'b1;
              r_mem_address    <= r_addr;
              r_mem_write_data <= r_wdata;
            end else begin
              r_state       <= RMW_RD;
              r_mem_read    <= 1'b1;
              r_mem_address <= r_addr;
            end
          end else if (req_bus.req_valid && r_req_ready) begin
            r_pending   <= 1'b1;
            r_req_ready <= 1'b0;
            r_write     <= req_bus.req_write;
            r_size      <= req_bus.req_size;
            r_unsigned  <= req_bus.req_unsigned;
            r_addr      <= req_bus.req_addr;
            r_wdata     <= req_bus.req_wdata;
          end
        end
        LOAD: begin
          r_state       <= RESP;
          r_mem_read    <= 1'b0;
          r_mem_address <= '0;
          r_resp_valid  <= 1'b1;
          r_resp_rdata  <= w_load_data;
        end
        RMW_RD: begin
          r_state          <= WRITE;
          r_mem_read       <= 1'b0;
          r_mem_write      <= 1'b1;
          r_mem_write_data <= w_store_data;
        end
        WRITE: begin
          r_state          <= RESP;
          r_mem_write      <= 1'b0;
          r_mem_address    <= '0;
          r_mem_write_data <= '0;
          r_resp_valid     <= 1'b1;
        end
        RESP: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_fault <= 1'b0;
          r_req_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_bus.req_ready      = r_req_ready;
  assign req_bus.resp_valid     = r_resp_valid;
  assign req_bus.resp_rdata     = r_resp_rdata;
  assign req_bus.resp_fault     = r_resp_fault;
  assign mem_bus.mem_address    = r_mem_address;
  assign mem_bus.mem_write_data = r_mem_write_data;
  assign mem_bus.mem_read       = r_mem_read;
  assign mem_bus.mem_write      = r_mem_write;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized self-checking bench for lsu_mem_master with a byte-array memory and a
// byte-level reference model of loads, stores, faults and per-cycle memory activity.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  localparam int MEM_BYTES = 1024;
  localparam int LAST      = MEM_BYTES - 8;
`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_req_if req_bus ();
  lsu_mem_if mem_bus ();

  lsu_mem_master #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_bus (req_bus),
    .mem_bus (mem_bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem     [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        poke_en = 1'b0;
  logic [63:0] poke_addr = '0;
  logic [63:0] poke_data = '0;

  // Memory: writes on the rising edge, reads combinationally while mem_read is high.
  always @(posedge clk) begin
    if (mem_bus.mem_write && mem_bus.mem_address <= 64'(LAST)) begin
      for (int i = 0; i < 8; i++) mem[int'(mem_bus.mem_address) + i] <= mem_bus.mem_write_data[8*i +: 8];
    end else if (poke_en) begin
      for (int i = 0; i < 8; i++) mem[int'(poke_addr) + i] <= poke_data[8*i +: 8];
    end
  end

  always_comb begin
    mem_bus.mem_read_data = '0;
    if (mem_bus.mem_read && mem_bus.mem_address <= 64'(LAST))
      for (int i = 0; i < 8; i++) mem_bus.mem_read_data[8*i +: 8] = mem[int'(mem_bus.mem_address) + i];
  end

  logic mon_both    = 1'b0;
  logic mon_addr_nz = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_bus.mem_read && mem_bus.mem_write) mon_both <= 1'b1;
      if (!mem_bus.mem_read && !mem_bus.mem_write && mem_bus.mem_address != 0) mon_addr_nz <= 1'b1;
    end
  end

  logic [63:0] d_rd;
  logic        d_flt;

  task automatic poke(input logic [63:0] addr, input logic [63:0] data);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = addr; poke_data = data;
    @(posedge clk); #1;
    poke_en = 1'b0;
    for (int i = 0; i < 8; i++) ref_mem[int'(addr) + i] = data[8*i +: 8];
  endtask

  // Reference: what the access must return, when, and which cycles touch memory.
  task automatic model(input bit wr, input logic [1:0] sz, input bit uns, input logic [63:0] addr,
                       input logic [63:0] wd, output logic [63:0] rd, output logic flt,
                       output int lat, output logic [7:0] rmask, output logic [7:0] wmask);
    int n;
    n = 1 << sz;
    flt = (addr > 64'(LAST)) || (ALIGN_EN && ((addr & 64'(n - 1)) != 0));
    rd = '0; rmask = '0; wmask = '0;
    if (flt) begin
      lat = 1;
    end else if (!wr) begin
      for (int i = 0; i < n; i++) rd[8*i +: 8] = ref_mem[int'(addr) + i];
      if (!uns && n < 8 && rd[8*n-1]) for (int i = n; i < 8; i++) rd[8*i +: 8] = 8'hFF;
      lat = 2; rmask[1] = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
      if (n == 8) begin lat = 2; wmask[1] = 1'b1; end
      else begin lat = 3; rmask[1] = 1'b1; wmask[2] = 1'b1; end
    end
  endtask

  task automatic run_op(input string name, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [63:0] addr, input logic [63:0] wd,
                        output logic [63:0] got_rd, output logic got_flt);
    logic [63:0] e_rd;
    logic        e_flt;
    int          e_lat, got_lat, diffs;
    logic [7:0]  e_rm, e_wm, got_rm, got_wm;
    model(wr, sz, uns, addr, wd, e_rd, e_flt, e_lat, e_rm, e_wm);
    @(negedge clk);
    n_cmp++;
    if (req_bus.req_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s ready_before: got %b want 1", name, req_bus.req_ready);
    end
    req_bus.req_valid = 1'b1; req_bus.req_write = wr; req_bus.req_size = sz;
    req_bus.req_unsigned = uns; req_bus.req_addr = addr; req_bus.req_wdata = wd;
    @(posedge clk); #1;
    // Hold valid with changed fields while busy: must be ignored.
    req_bus.req_write = 1'($urandom); req_bus.req_size = 2'($urandom); req_bus.req_unsigned = 1'($urandom);
    req_bus.req_addr = {$urandom, $urandom}; req_bus.req_wdata = {$urandom, $urandom};
    got_lat = 0; got_rm = '0; got_wm = '0; got_rd = '0; got_flt = 1'b0;
    for (int k = 1; k < 8 && got_lat == 0; k++) begin
      @(posedge clk); #1;
      if (mem_bus.mem_read)  got_rm[k] = 1'b1;
      if (mem_bus.mem_write) got_wm[k] = 1'b1;
      if (req_bus.resp_valid) begin
        got_lat = k; got_rd = req_bus.resp_rdata; got_flt = req_bus.resp_fault;
      end
    end
    req_bus.req_valid = 1'b0;
    n_cmp++;
    if (got_lat != e_lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", name, got_lat, e_lat); end
    n_cmp++;
    if (got_rd !== e_rd) begin n_bad++; $display("FAIL %s rdata: got %h want %h", name, got_rd, e_rd); end
    n_cmp++;
    if (got_flt !== e_flt) begin n_bad++; $display("FAIL %s fault: got %b want %b", name, got_flt, e_flt); end
    n_cmp++;
    if (got_rm !== e_rm) begin n_bad++; $display("FAIL %s mem_read_cycles: got %b want %b", name, got_rm, e_rm); end
    n_cmp++;
    if (got_wm !== e_wm) begin n_bad++; $display("FAIL %s mem_write_cycles: got %b want %b", name, got_wm, e_wm); end
    @(posedge clk); #1;
    n_cmp++;
    if (req_bus.resp_valid !== 1'b0 || req_bus.req_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s after_resp: got valid=%b ready=%b want valid=0 ready=1",
                        name, req_bus.resp_valid, req_bus.req_ready);
    end
    diffs = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) diffs++;
    n_cmp++;
    if (diffs != 0) begin n_bad++; $display("FAIL %s mem_image: got %0d differing bytes want 0", name, diffs); end
  endtask

  task automatic check_idle_outputs(input string name);
    n_cmp++;
    if ({req_bus.req_ready, req_bus.resp_valid, req_bus.resp_fault, mem_bus.mem_read, mem_bus.mem_write} !== 5'b10000) begin
      n_bad++; $display("FAIL %s flags: got rdy/rv/flt/rd/wr=%b want 10000", name,
        {req_bus.req_ready, req_bus.resp_valid, req_bus.resp_fault, mem_bus.mem_read, mem_bus.mem_write});
    end
    n_cmp++;
    if ({req_bus.resp_rdata, mem_bus.mem_address, mem_bus.mem_write_data} !== 192'd0) begin
      n_bad++; $display("FAIL %s data: got rdata=%h addr=%h wdata=%h want all 0", name,
        req_bus.resp_rdata, mem_bus.mem_address, mem_bus.mem_write_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_bus.req_valid = 1'b0; req_bus.req_write = 1'b0; req_bus.req_size = SZ_B;
    req_bus.req_unsigned = 1'b0; req_bus.req_addr = '0; req_bus.req_wdata = '0;
    #1;
    check_idle_outputs("reset_asserted");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("reset_released");
    for (int w = 0; w < MEM_BYTES / 8; w++) poke(64'(w * 8), {$urandom, $urandom});
  endtask

  task automatic test_directed();
    poke(64'h10, 64'h8877665544332211);
    run_op("ld_0x10", 1'b0, SZ_D, 1'b0, 64'h10, '0, d_rd, d_flt);
    n_cmp++;
    if (d_rd !== 64'h8877665544332211) begin n_bad++; $display("FAIL ld_0x10_value: got %h want 8877665544332211", d_rd); end
    poke(64'h10, 64'h8077665544332211);
    run_op("lb_0x17", 1'b0, SZ_B, 1'b0, 64'h17, '0, d_rd, d_flt);
    n_cmp++;
    if (d_rd !== 64'hFFFF_FFFF_FFFF_FF80) begin n_bad++; $display("FAIL lb_value: got %h want ffffffffffffff80", d_rd); end
    run_op("lbu_0x17", 1'b0, SZ_B, 1'b1, 64'h17, '0, d_rd, d_flt);
    n_cmp++;
    if (d_rd !== 64'h80) begin n_bad++; $display("FAIL lbu_value: got %h want 0000000000000080", d_rd); end
    poke(64'h20, 64'h1122334455667788);
    run_op("sh_0x20", 1'b1, SZ_H, 1'b0, 64'h20, 64'h0000_0000_0000_BEEF, d_rd, d_flt);
    n_cmp++;
    if ({mem[39], mem[38], mem[37], mem[36], mem[35], mem[34], mem[33], mem[32]} !== 64'h112233445566BEEF) begin
      n_bad++; $display("FAIL sh_window: got %h want 112233445566beef",
        {mem[39], mem[38], mem[37], mem[36], mem[35], mem[34], mem[33], mem[32]});
    end
    run_op("lw_1017", 1'b0, SZ_W, 1'b0, 64'd1017, '0, d_rd, d_flt);
    n_cmp++;
    if (d_flt !== 1'b1) begin n_bad++; $display("FAIL lw_1017_fault: got %b want 1", d_flt); end
    run_op("lw_0x102", 1'b0, SZ_W, 1'b0, 64'h102, '0, d_rd, d_flt);
    n_cmp++;
    if (d_flt !== ALIGN_EN) begin n_bad++; $display("FAIL lw_0x102_fault: got %b want %b", d_flt, ALIGN_EN); end
    run_op("sd_1016", 1'b1, SZ_D, 1'b0, 64'd1016, 64'hCAFE_F00D_1234_5678, d_rd, d_flt);
    run_op("lb_1016", 1'b0, SZ_B, 1'b0, 64'd1016, '0, d_rd, d_flt);
    run_op("sb_1017", 1'b1, SZ_B, 1'b0, 64'd1017, 64'h55, d_rd, d_flt);
    run_op("ld_huge", 1'b0, SZ_D, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, '0, d_rd, d_flt);
    run_op("sw_0x44", 1'b1, SZ_W, 1'b0, 64'h44, 64'hAAAA_BBBB_8765_4321, d_rd, d_flt);
  endtask

  task automatic test_random();
    logic [63:0] addr;
    for (int t = 0; t < 200; t++) begin
      addr = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, MEM_BYTES - 1));
      run_op($sformatf("rand_%0d", t), 1'($urandom), 2'($urandom), 1'($urandom), addr,
             {$urandom, $urandom}, d_rd, d_flt);
    end
  endtask

  task automatic test_reset_in_write();
    int   diffs;
    logic saw_wr, saw_resp;
    poke(64'h40, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    req_bus.req_valid = 1'b1; req_bus.req_write = 1'b1; req_bus.req_size = SZ_W;
    req_bus.req_unsigned = 1'b0; req_bus.req_addr = 64'h40; req_bus.req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    req_bus.req_valid = 1'b0;
    saw_wr = 1'b0;
    for (int k = 0; k < 6 && !saw_wr; k++) begin
      @(posedge clk); #1;
      saw_wr = mem_bus.mem_write;
    end
    n_cmp++;
    if (saw_wr !== 1'b1) begin n_bad++; $display("FAIL rst_write_reached: got %b want 1", saw_wr); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_outputs("rst_in_write");
    #1;
    reset = 1'b0;
    saw_resp = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (req_bus.resp_valid) saw_resp = 1'b1;
    end
    n_cmp++;
    if (saw_resp !== 1'b0) begin n_bad++; $display("FAIL rst_no_resp: got %b want 0", saw_resp); end
    diffs = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) diffs++;
    n_cmp++;
    if (diffs != 0) begin n_bad++; $display("FAIL rst_mem_image: got %0d differing bytes want 0", diffs); end
    run_op("ld_after_rst", 1'b0, SZ_D, 1'b0, 64'h40, '0, d_rd, d_flt);
    run_op("sw_after_rst", 1'b1, SZ_W, 1'b0, 64'h40, 64'h1357_9BDF, d_rd, d_flt);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_in_write();
    n_cmp++;
    if (mon_both !== 1'b0) begin n_bad++; $display("FAIL read_write_overlap: got %b want 0", mon_both); end
    n_cmp++;
    if (mon_addr_nz !== 1'b0) begin n_bad++; $display("FAIL idle_address_nonzero: got %b want 0", mon_addr_nz); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
